// File: rtl/ncl_fullword_reader_pkg.sv
// Shared NCL definitions: dual-rail codes and the reader FSM states.
package ncl_pkg;
    localparam logic [1:0] DR_NULL    = 2'b00;
    localparam logic [1:0] DR_ZERO    = 2'b01;
    localparam logic [1:0] DR_ONE     = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    typedef enum logic {WAIT_DATA, WAIT_NULL} state_e;
endpackage

// File: rtl/ncl_fullword_reader_if.sv
// Ring-side dual-rail word plus the clocked valid/ready output stream.
interface ncl_fullword_reader_if #(parameter int WIDTH = 32);
    logic [2*WIDTH-1:0] rail_in;
    logic               comp_out;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic [31:0]        word_cnt;
    logic               err_illegal;

    modport master (input rail_in, out_ready,
                    output comp_out, out_valid, out_data, word_cnt, err_illegal);
    modport slave  (output rail_in, out_ready,
                    input comp_out, out_valid, out_data, word_cnt, err_illegal);
endinterface

// File: rtl/ncl_word_fifo.sv
// Show-ahead word buffer; extra pointer MSB separates full from empty.
module ncl_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                  wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0][WIDTH-1:0]  mem_q, mem_d;
    logic                         do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero when empty so the output is defined right after reset.
    assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!init_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
endmodule

// File: rtl/ncl_fullword_reader.sv
// NCL-to-clocked boundary: synchronize dual-rail word, detect full DATA/NULL, ack the ring.
module ncl_fullword_reader
    import ncl_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  init_n,
    ncl_fullword_reader_if.master bus
);
    logic [SYNC_STAGES-1:0][2*WIDTH-1:0] sync_q, sync_d;
    logic [2*WIDTH-1:0] s, prev_q, prev_d;
    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               all_data, all_null, any_ill, stable;
    logic [WIDTH-1:0]   data_word, fifo_dout;
    logic               push, pop, full, empty;

    assign s      = sync_q[SYNC_STAGES-1];
    assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.rail_in};
    assign prev_d = s;
    // A wavefront only counts once two successive samples agree bit-for-bit.
    assign stable = (s == prev_q);
    assign pop    = bus.out_ready && !empty;

    always_comb begin
        all_data  = 1'b1;
        all_null  = 1'b1;
        any_ill   = 1'b0;
        data_word = '0;
        for (int i = 0; i < WIDTH; i++) begin
            data_word[i] = s[2*i+1];
            case (s[2*i +: 2])
                DR_NULL:         all_data = 1'b0;
                DR_ZERO, DR_ONE: all_null = 1'b0;
                default: begin
                    all_data = 1'b0;
                    all_null = 1'b0;
                    any_ill  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | any_ill;
        push    = 1'b0;
        case (state_q)
            WAIT_DATA: if (all_data && stable && !full) begin
                push    = 1'b1;
                cnt_d   = cnt_q + 32'd1;
                state_d = WAIT_NULL;
            end
            WAIT_NULL: if (all_null && stable) state_d = WAIT_DATA;
            default:   state_d = WAIT_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!init_n) begin
            sync_q  <= '0;
            prev_q  <= '0;
            state_q <= WAIT_DATA;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    ncl_word_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .init_n(init_n),
        .push  (push),
        .din   (data_word),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign bus.comp_out    = (state_q == WAIT_NULL);
    assign bus.out_valid   = !empty;
    assign bus.out_data    = fifo_dout;
    assign bus.word_cnt    = cnt_q;
    assign bus.err_illegal = err_q;
endmodule

// File: tb/tb_ncl_fullword_reader.sv
// Directed bench: ring handshake model around ncl_fullword_reader.
module tb_ncl_fullword_reader;
    localparam int W = 32;
    localparam int S = 2;
    localparam int LAT = S + 1;

    logic clk;
    logic init_n;
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;

    ncl_fullword_reader_if #(.WIDTH(W)) bus();

    ncl_fullword_reader #(.WIDTH(W), .SYNC_STAGES(S), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .init_n(init_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] w);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    // Waits for comp_out to reach target; lat = edges after the first one, -1 on timeout.
    task automatic ring_wait(input logic target, input int max, output int lat);
        lat = -1;
        for (int n = 1; n <= max; n++) begin
            @(posedge clk); #1;
            if (bus.comp_out === target) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    task automatic ring_data(input logic [W-1:0] w, input int max, output int lat);
        bus.rail_in = enc(w);
        ring_wait(1'b1, max, lat);
    endtask

    task automatic ring_null(input int max, output int lat);
        bus.rail_in = '0;
        ring_wait(1'b0, max, lat);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        init_n = 1'b0;
        bus.rail_in = enc(32'h5);
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.comp_out !== 1'b0) begin fails++; $display("FAIL rst_comp: got %b want 0", bus.comp_out); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
        tests++; if (bus.word_cnt !== 32'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", bus.word_cnt); end
        tests++; if (bus.out_data !== 32'd0) begin fails++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
        tests++; if (bus.err_illegal !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", bus.err_illegal); end
        bus.rail_in = '0;
        @(posedge clk); #1;
        init_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_handshake();
        int lat;
        ring_data(32'h5, 20, lat);
        tests++; if (lat != LAT) begin fails++; $display("FAIL hs_lat_d0: got %0d want %0d", lat, LAT); end
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h5) begin
            fails++; $display("FAIL hs_first: got v=%b d=%h want v=1 d=5", bus.out_valid, bus.out_data); end
        ring_null(20, lat);
        tests++; if (lat != LAT) begin fails++; $display("FAIL hs_lat_n0: got %0d want %0d", lat, LAT); end
        ring_data(32'h6, 20, lat);
        tests++; if (lat != LAT) begin fails++; $display("FAIL hs_lat_d1: got %0d want %0d", lat, LAT); end
        ring_null(20, lat);
        exp_cnt += 2;
        tests++; if (bus.word_cnt !== 32'(exp_cnt)) begin fails++; $display("FAIL hs_cnt: got %0d want %0d", bus.word_cnt, exp_cnt); end
        tests++; if (bus.out_data !== 32'h5) begin fails++; $display("FAIL hs_head0: got %h want 5", bus.out_data); end
        pop_one();
        tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h6) begin
            fails++; $display("FAIL hs_head1: got v=%b d=%h want v=1 d=6", bus.out_valid, bus.out_data); end
        pop_one();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL hs_empty: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_skewed();
        int  lat;
        logic early = 1'b0;
        bus.rail_in = '0;
        for (int k = 0; k < W; k++) begin
            bus.rail_in[2*k +: 2] = 2'b10;
            @(posedge clk); #1;
            if (bus.comp_out !== 1'b0 || bus.out_valid !== 1'b0) early = 1'b1;
        end
        tests++; if (early) begin fails++; $display("FAIL skew_early: got early capture want none"); end
        ring_wait(1'b1, 20, lat);
        exp_cnt++;
        tests++; if (lat < 0) begin fails++; $display("FAIL skew_capture: got timeout want comp_out=1"); end
        tests++; if (bus.out_data !== 32'hFFFF_FFFF) begin fails++; $display("FAIL skew_data: got %h want ffffffff", bus.out_data); end
        tests++; if (bus.word_cnt !== 32'(exp_cnt)) begin fails++; $display("FAIL skew_cnt: got %0d want %0d", bus.word_cnt, exp_cnt); end
        ring_null(20, lat);
        pop_one();
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            ring_data(32'(w), 20, lat);
            tests++; if (lat != LAT) begin fails++; $display("FAIL bp_cap%0d: got %0d want %0d", w, lat, LAT); end
            ring_null(20, lat);
        end
        exp_cnt += 4;
        ring_data(32'd5, 20, lat);
        tests++; if (lat != -1) begin fails++; $display("FAIL bp_held: got lat %0d want held (-1)", lat); end
        tests++; if (bus.comp_out !== 1'b0 || bus.word_cnt !== 32'(exp_cnt)) begin
            fails++; $display("FAIL bp_state: got comp=%b cnt=%0d want comp=0 cnt=%0d", bus.comp_out, bus.word_cnt, exp_cnt); end
        tests++; if (bus.out_data !== 32'd1) begin fails++; $display("FAIL bp_head: got %h want 1", bus.out_data); end
        pop_one();
        ring_wait(1'b1, 20, lat);
        exp_cnt++;
        tests++; if (lat < 0) begin fails++; $display("FAIL bp_release: got timeout want capture"); end
        ring_null(20, lat);
        for (int w = 2; w <= 5; w++) begin
            tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(w)) begin
                fails++; $display("FAIL bp_order%0d: got v=%b d=%h want v=1 d=%h", w, bus.out_valid, bus.out_data, w); end
            pop_one();
        end
        tests++; if (bus.out_valid !== 1'b0 || bus.word_cnt !== 32'(exp_cnt)) begin
            fails++; $display("FAIL bp_end: got v=%b cnt=%0d want v=0 cnt=%0d", bus.out_valid, bus.word_cnt, exp_cnt); end
    endtask

    task automatic test_illegal();
        int lat;
        logic [2*W-1:0] r;
        r = enc(32'h0);
        r[15:14] = 2'b11;
        bus.rail_in = r;
        repeat (6) @(posedge clk);
        #1;
        tests++; if (bus.err_illegal !== 1'b1) begin fails++; $display("FAIL ill_err: got %b want 1", bus.err_illegal); end
        tests++; if (bus.comp_out !== 1'b0 || bus.out_valid !== 1'b0 || bus.word_cnt !== 32'(exp_cnt)) begin
            fails++; $display("FAIL ill_nopush: got comp=%b v=%b cnt=%0d want 0 0 %0d", bus.comp_out, bus.out_valid, bus.word_cnt, exp_cnt); end
        ring_data(32'h80, 20, lat);
        exp_cnt++;
        tests++; if (lat != LAT) begin fails++; $display("FAIL ill_after_lat: got %0d want %0d", lat, LAT); end
        ring_null(20, lat);
        tests++; if (bus.out_data !== 32'h80) begin fails++; $display("FAIL ill_after_data: got %h want 80", bus.out_data); end
        tests++; if (bus.err_illegal !== 1'b1) begin fails++; $display("FAIL ill_sticky: got %b want 1", bus.err_illegal); end
        pop_one();
    endtask

    task automatic test_reset_mid();
        int lat;
        ring_data(32'hA5A5_0001, 20, lat);
        ring_null(20, lat);
        ring_data(32'h0000_BEEF, 20, lat);
        tests++; if (bus.comp_out !== 1'b1 || bus.out_valid !== 1'b1) begin
            fails++; $display("FAIL mid_setup: got comp=%b v=%b want 1 1", bus.comp_out, bus.out_valid); end
        init_n = 1'b0;
        bus.rail_in = '0;
        @(posedge clk); #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.comp_out !== 1'b0) begin
            fails++; $display("FAIL mid_clear: got v=%b comp=%b want 0 0", bus.out_valid, bus.comp_out); end
        tests++; if (bus.word_cnt !== 32'd0 || bus.err_illegal !== 1'b0) begin
            fails++; $display("FAIL mid_cnt: got cnt=%0d err=%b want 0 0", bus.word_cnt, bus.err_illegal); end
        init_n = 1'b1;
        exp_cnt = 0;
        @(posedge clk); #1;
        ring_data(32'h1234, 20, lat);
        exp_cnt++;
        tests++; if (lat != LAT) begin fails++; $display("FAIL mid_lat: got %0d want %0d", lat, LAT); end
        tests++; if (bus.out_data !== 32'h1234 || bus.word_cnt !== 32'(exp_cnt)) begin
            fails++; $display("FAIL mid_word: got d=%h cnt=%0d want d=1234 cnt=%0d", bus.out_data, bus.word_cnt, exp_cnt); end
        ring_null(20, lat);
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_skewed();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
